// File: rtl/avalon_multi_timer_if.sv
// Avalon-MM slave bus bundle for the multi-channel interval timer.
// Bus semantics: a write happens on every clock edge where chipselect=1 and write_n=0.
// A read needs no strobe: readdata is registered from address on every edge.
interface avalon_multi_timer_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/avalon_multi_timer.sv
// NUM_CH independent prescaled down-counters behind an Avalon-MM slave.
// Each channel provides one-shot/continuous timeouts, an IRQ bit and a registered PWM output.
module avalon_multi_timer #(
    parameter int NUM_CH       = 4,
    parameter int COUNT_W      = 32,
    parameter int DATA_W       = 32,
    parameter int RESET_PERIOD = 9999
) (
    input  logic                clk,
    input  logic                reset_n,
    avalon_multi_timer_if.slave bus,
    output logic                irq,
    output logic [NUM_CH-1:0]   irq_vec,
    output logic [NUM_CH-1:0]   pwm_out
);
    localparam int ADDR_W = $clog2(NUM_CH) + 3;
    localparam logic [2:0] REG_STATUS  = 3'd0;
    localparam logic [2:0] REG_CONTROL = 3'd1;
    localparam logic [2:0] REG_PERIOD  = 3'd2;
    localparam logic [2:0] REG_COMPARE = 3'd3;
    localparam logic [2:0] REG_COUNT   = 3'd4;
    localparam logic [COUNT_W-1:0] RST_PERIOD = COUNT_W'(RESET_PERIOD);

    logic [COUNT_W-1:0] r_count   [NUM_CH];
    logic [COUNT_W-1:0] r_period  [NUM_CH];
    logic [COUNT_W-1:0] r_compare [NUM_CH];
    logic [7:0]         r_prescale[NUM_CH];
    logic [7:0]         r_ps_cnt  [NUM_CH];
    logic [NUM_CH-1:0]  r_ito;
    logic [NUM_CH-1:0]  r_cont;
    logic [NUM_CH-1:0]  r_pwm_en;
    logic [NUM_CH-1:0]  r_to;
    logic [NUM_CH-1:0]  r_run;
    logic [NUM_CH-1:0]  r_reload;
    logic [NUM_CH-1:0]  r_pwm;
    logic [DATA_W-1:0]  r_readdata;

    logic               w_wr;
    logic [ADDR_W-1:0]  w_ch_idx;
    logic [2:0]         w_reg;
    logic [NUM_CH-1:0]  w_sel;
    logic [NUM_CH-1:0]  w_wr_status;
    logic [NUM_CH-1:0]  w_wr_ctrl;
    logic [NUM_CH-1:0]  w_wr_period;
    logic [NUM_CH-1:0]  w_wr_compare;
    logic               w_start;
    logic               w_stop;
    logic [NUM_CH-1:0]  w_tick;
    logic [NUM_CH-1:0]  w_timeout;
    logic [NUM_CH-1:0]  w_run_nxt;
    logic [NUM_CH-1:0]  w_to_nxt;
    logic [NUM_CH-1:0]  w_pwm_nxt;
    logic [DATA_W-1:0]  w_rdata;
    logic               w_unused_wdata;

    assign w_wr           = bus.chipselect & ~bus.write_n;
    assign w_ch_idx       = bus.address >> 3;
    assign w_reg          = bus.address[2:0];
    assign w_start        = bus.writedata[2];
    assign w_stop         = bus.writedata[3];
    assign w_unused_wdata = &{1'b0, bus.writedata};

    always_comb begin
        w_sel        = '0;
        w_wr_status  = '0;
        w_wr_ctrl    = '0;
        w_wr_period  = '0;
        w_wr_compare = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_sel[i]        = w_wr && (w_ch_idx == ADDR_W'(i));
            w_wr_status[i]  = w_sel[i] && (w_reg == REG_STATUS);
            w_wr_ctrl[i]    = w_sel[i] && (w_reg == REG_CONTROL);
            w_wr_period[i]  = w_sel[i] && (w_reg == REG_PERIOD);
            w_wr_compare[i] = w_sel[i] && (w_reg == REG_COMPARE);
        end
    end

    // Priority of RUN updates, lowest first: one-shot timeout, START, STOP, force-reload.
    always_comb begin
        w_tick    = '0;
        w_timeout = '0;
        w_run_nxt = '0;
        w_to_nxt  = '0;
        w_pwm_nxt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_tick[i]    = r_run[i] & ~r_reload[i] & (r_ps_cnt[i] == r_prescale[i]);
            w_timeout[i] = w_tick[i] & (r_count[i] == '0);

            w_run_nxt[i] = r_run[i];
            if (w_timeout[i] && !r_cont[i]) w_run_nxt[i] = 1'b0;
            if (w_wr_ctrl[i] && w_start)    w_run_nxt[i] = 1'b1;
            if (w_wr_ctrl[i] && w_stop)     w_run_nxt[i] = 1'b0;
            if (r_reload[i])                w_run_nxt[i] = 1'b0;

            w_to_nxt[i] = r_to[i];
            if (w_wr_status[i]) w_to_nxt[i] = 1'b0;
            if (w_timeout[i])   w_to_nxt[i] = 1'b1;

            w_pwm_nxt[i] = r_run[i] & r_pwm_en[i] & (r_count[i] < r_compare[i]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_count[i]    <= RST_PERIOD;
                r_period[i]   <= RST_PERIOD;
                r_compare[i]  <= '0;
                r_prescale[i] <= '0;
                r_ps_cnt[i]   <= '0;
            end
            r_ito    <= '0;
            r_cont   <= '0;
            r_pwm_en <= '0;
            r_to     <= '0;
            r_run    <= '0;
            r_reload <= '0;
            r_pwm    <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                // The cycle after a PERIOD write is spent reloading; no tick is taken then.
                if (r_reload[i]) begin
                    r_count[i]  <= r_period[i];
                    r_ps_cnt[i] <= '0;
                end else if (r_run[i]) begin
                    r_ps_cnt[i] <= w_tick[i] ? 8'd0 : r_ps_cnt[i] + 8'd1;
                    if (w_tick[i]) begin
                        r_count[i] <= (r_count[i] == '0) ? r_period[i]
                                                         : r_count[i] - COUNT_W'(1);
                    end
                end

                if (w_wr_ctrl[i]) begin
                    r_ito[i]      <= bus.writedata[0];
                    r_cont[i]     <= bus.writedata[1];
                    r_pwm_en[i]   <= bus.writedata[4];
                    r_prescale[i] <= bus.writedata[15:8];
                end
                if (w_wr_period[i])  r_period[i]  <= bus.writedata[COUNT_W-1:0];
                if (w_wr_compare[i]) r_compare[i] <= bus.writedata[COUNT_W-1:0];
            end
            r_run    <= w_run_nxt;
            r_to     <= w_to_nxt;
            r_reload <= w_wr_period;
            r_pwm    <= w_pwm_nxt;
        end
    end

    always_comb begin
        w_rdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_ch_idx == ADDR_W'(i)) begin
                case (w_reg)
                    REG_STATUS:  w_rdata = DATA_W'({r_run[i], r_to[i]});
                    REG_CONTROL: w_rdata = DATA_W'({r_prescale[i], 3'b000, r_pwm_en[i],
                                                    2'b00, r_cont[i], r_ito[i]});
                    REG_PERIOD:  w_rdata = DATA_W'(r_period[i]);
                    REG_COMPARE: w_rdata = DATA_W'(r_compare[i]);
                    REG_COUNT:   w_rdata = DATA_W'(r_count[i]);
                    default:     w_rdata = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_readdata <= '0;
        else          r_readdata <= w_rdata;
    end

    assign bus.readdata = r_readdata;
    assign irq_vec      = r_to & r_ito;
    assign irq          = |irq_vec;
    assign pwm_out      = r_pwm;
endmodule

// File: tb/tb_avalon_multi_timer.sv
// Bench for avalon_multi_timer: directed scenarios plus random bus traffic, with a
// cycle-level reference model feeding an expected queue that a monitor drains each cycle.
module tb_avalon_multi_timer;
    localparam int NUM_CH       = 4;
    localparam int COUNT_W      = 16;
    localparam int DATA_W       = 32;
    localparam int RESET_PERIOD = 9999;
    localparam int ADDR_W       = 5;
    localparam int EW           = DATA_W + 2 * NUM_CH;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              irq;
    logic [NUM_CH-1:0] irq_vec;
    logic [NUM_CH-1:0] pwm_out;

    avalon_multi_timer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    avalon_multi_timer #(
        .NUM_CH(NUM_CH), .COUNT_W(COUNT_W), .DATA_W(DATA_W), .RESET_PERIOD(RESET_PERIOD)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus),
        .irq(irq), .irq_vec(irq_vec), .pwm_out(pwm_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [EW-1:0] exp_q[$];

    // Reference model state, one entry per channel.
    int unsigned m_count[NUM_CH], m_period[NUM_CH], m_compare[NUM_CH];
    int unsigned m_prescale[NUM_CH], m_ps[NUM_CH];
    bit m_ito[NUM_CH], m_cont[NUM_CH], m_pwm_en[NUM_CH];
    bit m_to[NUM_CH], m_run[NUM_CH], m_reload[NUM_CH];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_count[i] = RESET_PERIOD; m_period[i] = RESET_PERIOD; m_compare[i] = 0;
            m_prescale[i] = 0; m_ps[i] = 0;
            m_ito[i] = 0; m_cont[i] = 0; m_pwm_en[i] = 0;
            m_to[i] = 0; m_run[i] = 0; m_reload[i] = 0;
        end
    endtask

    task automatic model_step();
        bit wr;
        int ch, rg;
        logic [31:0] wd, rd;
        logic [NUM_CH-1:0] e_pwm, e_irqv;
        wr = (bus.chipselect === 1'b1) && (bus.write_n === 1'b0);
        ch = int'(bus.address) / 8;
        rg = int'(bus.address) % 8;
        wd = bus.writedata;
        rd = 0;
        if (ch < NUM_CH) begin
            case (rg)
                0: rd = 2 * m_run[ch] + m_to[ch];
                1: rd = 256 * m_prescale[ch] + 16 * m_pwm_en[ch] + 2 * m_cont[ch] + m_ito[ch];
                2: rd = m_period[ch];
                3: rd = m_compare[ch];
                4: rd = m_count[ch];
                default: rd = 0;
            endcase
        end
        for (int i = 0; i < NUM_CH; i++) begin
            bit tick, tmo, n_run, n_to, n_rel;
            int unsigned n_count, n_ps;
            e_pwm[i] = m_run[i] && m_pwm_en[i] && (m_count[i] < m_compare[i]);
            tick = m_run[i] && !m_reload[i] && (m_ps[i] == m_prescale[i]);
            tmo = tick && (m_count[i] == 0);
            n_count = m_count[i]; n_ps = m_ps[i]; n_run = m_run[i]; n_to = m_to[i]; n_rel = 0;
            if (m_reload[i]) begin
                n_count = m_period[i]; n_ps = 0;
            end else if (m_run[i]) begin
                n_ps = tick ? 0 : (m_ps[i] + 1) % 256;
                if (tick) n_count = (m_count[i] == 0) ? m_period[i] : m_count[i] - 1;
            end
            if (tmo) begin
                n_to = 1;
                if (!m_cont[i]) n_run = 0;
            end
            if (wr && ch == i) begin
                case (rg)
                    0: if (!tmo) n_to = 0;
                    1: begin
                        m_ito[i] = wd[0]; m_cont[i] = wd[1]; m_pwm_en[i] = wd[4];
                        m_prescale[i] = wd[15:8];
                        if (wd[2]) n_run = 1;
                        if (wd[3]) n_run = 0;
                    end
                    2: begin m_period[i] = wd % 65536; n_rel = 1; end
                    3: m_compare[i] = wd % 65536;
                    default: ;
                endcase
            end
            if (m_reload[i]) n_run = 0;
            m_count[i] = n_count; m_ps[i] = n_ps; m_run[i] = n_run;
            m_to[i] = n_to; m_reload[i] = n_rel;
            e_irqv[i] = m_to[i] && m_ito[i];
        end
        exp_q.push_back({rd, e_irqv, e_pwm});
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            model_reset();
            exp_q.delete();
        end else begin
            model_step();
        end
    end

    always @(negedge clk) begin
        if (reset_n && exp_q.size() > 0) begin
            logic [EW-1:0] e;
            e = exp_q.pop_front();
            check("readdata", bus.readdata, e[EW-1:2*NUM_CH]);
            check("irq_vec", irq_vec, e[2*NUM_CH-1:NUM_CH]);
            check("irq", irq, |e[2*NUM_CH-1:NUM_CH]);
            check("pwm_out", pwm_out, e[NUM_CH-1:0]);
        end
    end

    task automatic bus_idle(int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic bus_write(logic [ADDR_W-1:0] a, logic [31:0] d);
        bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.writedata = d;
        @(posedge clk); #1;
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
    endtask

    task automatic bus_read(logic [ADDR_W-1:0] a, output logic [31:0] d);
        bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b1;
        @(posedge clk); #1;
        bus.chipselect = 1'b0;
        d = bus.readdata;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int ones;
        bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_readdata", bus.readdata, 0);
        check("rst_irq", irq, 0);
        check("rst_irq_vec", irq_vec, 0);
        check("rst_pwm", pwm_out, 0);
        reset_n = 1'b1;
        bus_idle(1);
        bus_read(5'd4, rd);  check("rst_count0", rd, RESET_PERIOD);
        bus_read(5'd2, rd);  check("rst_period0", rd, RESET_PERIOD);

        // Ch0: continuous, period 5, timeout on 6th tick
        bus_write(5'd2, 5);
        bus_idle(1);
        bus_write(5'd1, 32'h07);
        bus_idle(5);  check("ch0_irq_before", irq, 0);
        bus_idle(1);  check("ch0_irq_6th", irq, 1);
        bus_write(5'd0, 0);  check("ch0_irq_cleared", irq, 0);
        bus_idle(4);  check("ch0_irq_quiet", irq, 0);
        bus_idle(1);  check("ch0_irq_again", irq, 1);
        bus_write(5'd1, 32'h0B);
        bus_write(5'd0, 0);

        // Ch1: one-shot, period 3, prescale 3
        bus_write(5'd10, 3);
        bus_idle(1);
        bus_write(5'd9, 32'h0305);
        bus_idle(15); check("ch1_irq_before", irq_vec[1], 0);
        bus_idle(1);  check("ch1_irq_16", irq_vec[1], 1);
        bus_read(5'd8, rd);  check("ch1_status", rd, 1);
        bus_read(5'd12, rd); check("ch1_count", rd, 3);
        bus_idle(10);
        bus_read(5'd12, rd); check("ch1_count_hold", rd, 3);
        bus_write(5'd8, 0);

        // Ch2: PWM duty 3/10, then COMPARE=0
        bus_write(5'd18, 9);
        bus_idle(1);
        bus_write(5'd19, 3);
        bus_write(5'd17, 32'h16);
        bus_idle(5);
        ones = 0;
        repeat (100) begin @(posedge clk); #1; ones += int'(pwm_out[2]); end
        check("ch2_pwm_duty", ones, 30);
        bus_write(5'd19, 0);
        bus_idle(2);
        ones = 0;
        repeat (20) begin @(posedge clk); #1; ones += int'(pwm_out[2]); end
        check("ch2_pwm_cmp0", ones, 0);
        bus_write(5'd17, 32'h1A);

        // Ch3 collisions: STATUS clear on the timeout edge
        bus_write(5'd26, 2);
        bus_idle(1);
        bus_write(5'd25, 32'h07);
        bus_idle(2);
        bus_write(5'd24, 0);
        check("ch3_to_wins", irq_vec[3], 1);
        bus_read(5'd24, rd); check("ch3_status_to_wins", rd, 3);
        bus_write(5'd25, 32'h0B);
        bus_write(5'd24, 0);
        // START|STOP together
        bus_write(5'd25, 32'h0C);
        bus_read(5'd24, rd); check("ch3_start_stop", rd, 0);
        // PERIOD write while running
        bus_write(5'd25, 32'h07);
        bus_idle(3);
        bus_write(5'd26, 50);
        bus_idle(1);
        bus_read(5'd24, rd); check("ch3_reload_run", rd & 2, 0);
        bus_read(5'd28, rd); check("ch3_reload_count", rd, 50);
        // START landing in the force-reload cycle
        bus_write(5'd26, 40);
        bus_write(5'd25, 32'h07);
        bus_read(5'd24, rd); check("ch3_reload_vs_start", rd & 2, 0);
        bus_read(5'd28, rd); check("ch3_reload_count2", rd, 40);
        bus_write(5'd24, 0);

        // Concurrent ch0/ch3, then asynchronous reset mid-count
        bus_write(5'd2, 100);
        bus_idle(1);
        bus_write(5'd3, 150);
        bus_write(5'd1, 32'h17);
        bus_write(5'd26, 200);
        bus_idle(1);
        bus_write(5'd25, 32'h07);
        bus_idle(30);
        check("conc_pwm0_high", pwm_out[0], 1);
        bus_read(5'd28, rd);
        check("conc_ch3_running", (rd < 200) ? 1 : 0, 1);
        #1 reset_n = 1'b0;
        #1;
        check("async_readdata", bus.readdata, 0);
        check("async_irq", irq, 0);
        check("async_irq_vec", irq_vec, 0);
        check("async_pwm", pwm_out, 0);
        #10 reset_n = 1'b1;
        bus_idle(1);
        bus_read(5'd4, rd);  check("post_rst_count0", rd, RESET_PERIOD);
        bus_read(5'd28, rd); check("post_rst_count3", rd, RESET_PERIOD);
        bus_read(5'd2, rd);  check("post_rst_period0", rd, RESET_PERIOD);
        bus_read(5'd24, rd); check("post_rst_status3", rd, 0);

        // Random traffic, checked cycle by cycle against the model
        for (int n = 0; n < 1500; n++) begin
            int op;
            logic [ADDR_W-1:0] a;
            logic [31:0] d;
            op = $urandom_range(0, 3);
            a = ADDR_W'($urandom_range(0, 31));
            case (a[2:0])
                3'd1:    d = 32'($urandom_range(0, 3) * 256 + $urandom_range(0, 31));
                3'd2:    d = 32'($urandom_range(0, 12));
                3'd3:    d = 32'($urandom_range(0, 15));
                default: d = $urandom;
            endcase
            if (op == 0)      bus_idle(1);
            else if (op == 1) bus_read(a, rd);
            else              bus_write(a, d);
        end
        bus_idle(3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
